// File: rtl/bcd_serial_add_ctrl_pkg.sv
// Shared definitions for the digit-serial BCD adder controller.
//
// Contents:
//   BCD_MAX  - largest legal BCD digit value
//   BCD_CORR - correction added to a binary digit sum that exceeds BCD_MAX
//   state_t  - controller FSM encoding (IDLE waits for start, RUN walks digits)
package bcd_serial_add_ctrl_pkg;

  localparam logic [3:0] BCD_MAX  = 4'd9;
  localparam logic [3:0] BCD_CORR = 4'd6;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/bcd_serial_add_ctrl_if.sv
// Handshake and data bundle between the operand source and the serial BCD
// adder controller.
//
// Signals:
//   start   - request a new addition (sampled only while the controller idles)
//   a_bcd   - operand A, packed BCD, digit 0 in [3:0]
//   b_bcd   - operand B, same packing
//   busy    - controller is stepping through digits
//   done    - one-cycle pulse, result fields valid
//   sum_bcd - result digits, same packing as the operands
//   cout    - carry out of the most significant digit
//   err     - some operand digit of the current operation was above 9
//
// Modports:
//   master - operand source / display side
//   slave  - the controller
interface bcd_serial_add_ctrl_if #(
  parameter int DIGITS = 4
);

  logic                  start;
  logic [4*DIGITS-1:0]   a_bcd;
  logic [4*DIGITS-1:0]   b_bcd;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   sum_bcd;
  logic                  cout;
  logic                  err;

  modport master (
    output start, a_bcd, b_bcd,
    input  busy, done, sum_bcd, cout, err
  );

  modport slave (
    input  start, a_bcd, b_bcd,
    output busy, done, sum_bcd, cout, err
  );

endinterface

// File: rtl/bcd_serial_add_ctrl_digit_add.sv
// Combinational single-digit BCD adder slice, shared by the serial controller.
//
// Ports:
//   a, b    - input digits (may be illegal values 10..15)
//   cin     - carry in from the previous digit
//   d       - corrected result digit
//   cout    - decimal carry out
//   invalid - either input digit is above 9
//
// Illegal input digits are not special-cased: the same binary-sum-plus-
// correction rule is applied, the caller only gets the invalid flag.
module bcd_digit_add
  import bcd_serial_add_ctrl_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] d,
  output logic       cout,
  output logic       invalid
);

  logic [4:0] sum5;

  // Binary digit sum, then decimal correction when it leaves the BCD range.
  // Adding the correction in 4 bits gives exactly the low nibble of the
  // 5-bit corrected sum.
  always_comb begin
    sum5 = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
    d    = sum5[3:0];
    cout = 1'b0;
    if (sum5 > {1'b0, BCD_MAX}) begin
      d    = sum5[3:0] + BCD_CORR;
      cout = 1'b1;
    end
  end

  assign invalid = (a > BCD_MAX) || (b > BCD_MAX);

endmodule

// File: rtl/bcd_serial_add_ctrl.sv
// Digit-serial BCD addition controller.
//
// Adds two DIGITS-wide packed-BCD operands one digit per clock, least
// significant digit first, through a single shared bcd_digit_add slice and a
// ripple carry register. Operands are latched when start is accepted, so the
// source may change them during the operation.
//
// Ports:
//   clk - rising-edge clock
//   rst - synchronous, active-high reset (aborts any operation in progress)
//   bus - slave side of bcd_serial_add_ctrl_if (start/busy/done, operands,
//         result, carry out and sticky invalid-digit flag)
//
// All bus outputs come straight from registers.
module bcd_serial_add_ctrl
  import bcd_serial_add_ctrl_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  bcd_serial_add_ctrl_if.slave  bus
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  state_t                state;
  state_t                state_next;

  logic [IDX_W-1:0]      idx;
  logic                  carry;
  logic [4*DIGITS-1:0]   a_reg;
  logic [4*DIGITS-1:0]   b_reg;
  logic [4*DIGITS-1:0]   sum_reg;
  logic                  cout_reg;
  logic                  err_reg;
  logic                  done_reg;

  logic                  load;
  logic                  step;
  logic                  last_digit;

  logic [3:0]            digit_sum;
  logic                  digit_carry;
  logic                  digit_invalid;

  bcd_digit_add u_digit_add (
    .a       (a_reg[4*idx +: 4]),
    .b       (b_reg[4*idx +: 4]),
    .cin     (carry),
    .d       (digit_sum),
    .cout    (digit_carry),
    .invalid (digit_invalid)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // load: accept a request in IDLE. step: process digit idx in RUN; the
  // last digit returns to IDLE so a new start can be taken in the done cycle.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    last_digit = (idx == LAST_IDX);
    case (state)
      IDLE: begin
        if (bus.start) begin
          load       = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (last_digit) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: operand latch, digit index, ripple carry and result registers.
  // Results hold after done until the next accepted start or reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx      <= '0;
      carry    <= 1'b0;
      a_reg    <= '0;
      b_reg    <= '0;
      sum_reg  <= '0;
      cout_reg <= 1'b0;
      err_reg  <= 1'b0;
      done_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (load) begin
        a_reg    <= bus.a_bcd;
        b_reg    <= bus.b_bcd;
        idx      <= '0;
        carry    <= 1'b0;
        sum_reg  <= '0;
        cout_reg <= 1'b0;
        err_reg  <= 1'b0;
      end else if (step) begin
        sum_reg[4*idx +: 4] <= digit_sum;
        carry               <= digit_carry;
        if (digit_invalid) err_reg <= 1'b1;
        if (last_digit) begin
          cout_reg <= digit_carry;
          done_reg <= 1'b1;
          idx      <= '0;
        end else begin
          idx <= idx + 1'b1;
        end
      end
    end
  end

  assign bus.busy    = (state == RUN);
  assign bus.done    = done_reg;
  assign bus.sum_bcd = sum_reg;
  assign bus.cout    = cout_reg;
  assign bus.err     = err_reg;

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Self-checking bench for bcd_serial_add_ctrl: directed cases, randomized
// operands against a decimal reference model, back-to-back handshake and
// reset abort.
module tb_bcd_serial_add_ctrl;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;

  logic clk = 1'b0;
  logic rst;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bcd_serial_add_ctrl_if #(.DIGITS(DIGITS)) bus ();

  bcd_serial_add_ctrl #(.DIGITS(DIGITS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference: legal operands are added as decimal numbers; when any digit is
  // illegal the digit-wise rule (binary sum, +6 when above 9) is applied.
  function automatic void ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] s, output logic c,
                                  output logic e);
    longint va, vb, vs, pw, lim;
    int ad, bd, ds, cy;
    e  = 1'b0;
    va = 0;
    vb = 0;
    pw = 1;
    for (int i = 0; i < DIGITS; i++) begin
      ad = int'(a[4*i +: 4]);
      bd = int'(b[4*i +: 4]);
      if (ad > 9 || bd > 9) e = 1'b1;
      va += ad * pw;
      vb += bd * pw;
      pw *= 10;
    end
    lim = pw;
    s   = '0;
    if (!e) begin
      vs = va + vb;
      c  = (vs >= lim);
      vs = vs % lim;
      for (int i = 0; i < DIGITS; i++) begin
        s[4*i +: 4] = 4'(vs % 10);
        vs          = vs / 10;
      end
    end else begin
      cy = 0;
      for (int i = 0; i < DIGITS; i++) begin
        ds = int'(a[4*i +: 4]) + int'(b[4*i +: 4]) + cy;
        if (ds > 9) begin
          ds = (ds + 6) % 16;
          cy = 1;
        end else begin
          cy = 0;
        end
        s[4*i +: 4] = 4'(ds);
      end
      c = (cy != 0);
    end
  endfunction

  function automatic logic [W-1:0] rand_operand(input bit allow_bad);
    logic [W-1:0] v;
    for (int i = 0; i < DIGITS; i++) begin
      if (allow_bad && $urandom_range(0, 5) == 0) v[4*i +: 4] = 4'($urandom_range(10, 15));
      else                                        v[4*i +: 4] = 4'($urandom_range(0, 9));
    end
    return v;
  endfunction

  // Present a request for one edge, then scramble the inputs.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
    bus.start = 1'b1;
    bus.a_bcd = a;
    bus.b_bcd = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.a_bcd = W'($urandom);
    bus.b_bcd = W'($urandom);
  endtask

  task automatic wait_done(output int lat, output bit ok);
    ok  = 1'b0;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        lat = k;
        ok  = 1'b1;
        return;
      end
    end
  endtask

  task automatic compare_result(input string name, input logic [W-1:0] a,
                                input logic [W-1:0] b);
    logic [W-1:0] es;
    logic ec, ee;
    ref_add(a, b, es, ec, ee);
    checks++;
    if (bus.sum_bcd !== es) begin
      errors++;
      $display("[TB] FAIL %s sum: got %h expected %h (a=%h b=%h)", name, bus.sum_bcd, es, a, b);
    end
    checks++;
    if (bus.cout !== ec) begin
      errors++;
      $display("[TB] FAIL %s cout: got %b expected %b (a=%h b=%h)", name, bus.cout, ec, a, b);
    end
    checks++;
    if (bus.err !== ee) begin
      errors++;
      $display("[TB] FAIL %s err: got %b expected %b (a=%h b=%h)", name, bus.err, ee, a, b);
    end
  endtask

  // Full operation with latency, busy and single-pulse checks.
  task automatic check_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b);
    int lat;
    bit ok;
    start_op(a, b);
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s busy_after_start: got %b expected 1", name, bus.busy);
    end
    wait_done(lat, ok);
    checks++;
    if (!ok || lat != DIGITS) begin
      errors++;
      $display("[TB] FAIL %s latency: got %0d (seen=%0d) expected %0d", name, lat, ok, DIGITS);
    end
    if (ok) begin
      compare_result(name, a, b);
      checks++;
      if (bus.busy !== 1'b0) begin
        errors++;
        $display("[TB] FAIL %s busy_at_done: got %b expected 0", name, bus.busy);
      end
      @(posedge clk); #1;
      checks++;
      if (bus.done !== 1'b0) begin
        errors++;
        $display("[TB] FAIL %s done_pulse_width: got %b expected 0", name, bus.done);
      end
      compare_result({name, "_hold"}, a, b);
    end
  endtask

  task automatic check_idle_zero(input string name);
    checks++;
    if ({bus.busy, bus.done, bus.sum_bcd, bus.cout, bus.err} !== '0) begin
      errors++;
      $display("[TB] FAIL %s: got busy=%b done=%b sum=%h cout=%b err=%b expected all 0",
               name, bus.busy, bus.done, bus.sum_bcd, bus.cout, bus.err);
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a_bcd = '0;
    bus.b_bcd = '0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_zero("reset_values");
    // Reset wins over a simultaneous start.
    bus.start = 1'b1;
    bus.a_bcd = 16'h1234;
    bus.b_bcd = 16'h4321;
    @(posedge clk); #1;
    check_idle_zero("reset_over_start");
    bus.start = 1'b0;
    rst       = 1'b0;
    @(posedge clk); #1;
    check_idle_zero("idle_after_reset");
  endtask

  task automatic test_directed();
    check_op("add_1234_4321", 16'h1234, 16'h4321);
    check_op("add_9999_0001", 16'h9999, 16'h0001);
    check_op("add_0958_0047", 16'h0958, 16'h0047);
    check_op("add_00A3_0001", 16'h00A3, 16'h0001);
    check_op("add_9999_9999", 16'h9999, 16'h9999);
  endtask

  task automatic test_random();
    logic [W-1:0] a, b;
    for (int n = 0; n < 30; n++) begin
      a = rand_operand(n >= 20);
      b = rand_operand(n >= 20);
      check_op($sformatf("random_%0d", n), a, b);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a1, b1, a2, b2;
    int lat, extra;
    bit ok;
    a1 = rand_operand(1'b0);
    b1 = rand_operand(1'b0);
    a2 = rand_operand(1'b1);
    b2 = rand_operand(1'b0);
    bus.start = 1'b1;
    bus.a_bcd = a1;
    bus.b_bcd = b1;
    @(posedge clk); #1;
    // start stays high through RUN with unrelated operands on the bus.
    bus.a_bcd = 16'h7777;
    bus.b_bcd = 16'h8888;
    wait_done(lat, ok);
    checks++;
    if (!ok || lat != DIGITS) begin
      errors++;
      $display("[TB] FAIL b2b_first_latency: got %0d (seen=%0d) expected %0d", lat, ok, DIGITS);
    end
    compare_result("b2b_first", a1, b1);
    bus.a_bcd = a2;
    bus.b_bcd = b2;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.a_bcd = W'($urandom);
    bus.b_bcd = W'($urandom);
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL b2b_accept_in_done_cycle: got busy=%b expected 1", bus.busy);
    end
    wait_done(lat, ok);
    checks++;
    if (!ok || lat != DIGITS) begin
      errors++;
      $display("[TB] FAIL b2b_second_latency: got %0d (seen=%0d) expected %0d", lat, ok, DIGITS);
    end
    compare_result("b2b_second", a2, b2);
    extra = 0;
    for (int k = 0; k < 2 * DIGITS + 2; k++) begin
      @(posedge clk); #1;
      if (bus.done) extra++;
    end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("[TB] FAIL b2b_extra_done: got %0d extra done pulses expected 0", extra);
    end
  endtask

  task automatic test_reset_abort();
    int dones;
    start_op(16'h123B, 16'h4560);
    @(posedge clk); #1;
    checks++;
    if (bus.err !== 1'b1) begin
      errors++;
      $display("[TB] FAIL abort_err_set_before_reset: got %b expected 1", bus.err);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_idle_zero("abort_outputs_cleared");
    dones = 0;
    for (int k = 0; k < DIGITS + 3; k++) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) dones++;
    end
    checks++;
    if (dones != 0) begin
      errors++;
      $display("[TB] FAIL abort_no_done: got %0d cycles with done/busy expected 0", dones);
    end
    check_op("after_abort", 16'h0958, 16'h0047);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
